// File: rtl/vram_blitter_pkg.sv
// Shared definitions for the video RAM blitter: register map, control bits and FSM encoding.
package vram_blitter_pkg;

   localparam logic [3:0] REG_SRC_LO   = 4'd0;
   localparam logic [3:0] REG_SRC_HI   = 4'd1;
   localparam logic [3:0] REG_DST_LO   = 4'd2;
   localparam logic [3:0] REG_DST_HI   = 4'd3;
   localparam logic [3:0] REG_LEN_LO   = 4'd4;
   localparam logic [3:0] REG_LEN_HI   = 4'd5;
   localparam logic [3:0] REG_FILL     = 4'd6;
   localparam logic [3:0] REG_CTRL     = 4'd7;
   localparam logic [3:0] REG_DONE_CLR = 4'd8;

   localparam int unsigned CTL_START  = 0;
   localparam int unsigned CTL_MODE   = 1;
   localparam int unsigned CTL_IRQ_EN = 2;
   localparam int unsigned CTL_ABORT  = 3;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StRd   = 3'd1,
      StCap  = 3'd2,
      StWr   = 3'd3,
      StFin  = 3'd4
   } blit_state_e;

endpackage

// File: rtl/vram_blitter.sv
// CPU-programmed DMA engine writing video RAM by block copy or constant fill.
// Holds the register page, the src/dst/len counters and the transfer FSM.
module vram_blitter
   import vram_blitter_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic             cpu_clk,
   input  logic             rst,
   input  logic [3:0]       cpu_addr,
   input  logic [7:0]       cpu_dbw,
   input  logic             cpu_we,
   output logic [7:0]       cpu_dbr,
   output logic             cpu_irq,
   output logic [LEN_W-1:0] mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [7:0]       mem_dbw,
   input  logic [7:0]       mem_dbr,
   input  logic             mem_ready
);

   blit_state_e      state_q, state_d;
   logic [LEN_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [7:0]       fill_q, fill_d, data_q, data_d, dbr_d;
   logic             mode_q, mode_d, irq_en_q, irq_en_d, done_q, done_d;
   logic             busy, ctrl_wr, start_req, abort_req, xfer;

   assign busy      = (state_q != StIdle);
   assign ctrl_wr   = cpu_we && (cpu_addr == REG_CTRL);
   assign start_req = ctrl_wr && !busy && cpu_dbw[CTL_START];
   assign abort_req = ctrl_wr && busy && cpu_dbw[CTL_ABORT];
   // An abort drops the write offered in the same cycle, so counters stay put.
   assign xfer      = (state_q == StWr) && mem_ready && !abort_req;
   assign cpu_irq   = done_q && irq_en_q;

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_req) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_req) begin
                  // Zero length skips straight to completion without touching memory.
                  if (len_q == '0)               state_d = StFin;
                  else if (cpu_dbw[CTL_MODE])    state_d = StWr;
                  else                           state_d = StRd;
               end
            end
            StRd:    if (mem_ready) state_d = StCap;
            StCap:   state_d = StWr;
            StWr: begin
               if (mem_ready) begin
                  if (len_q == LEN_W'(1)) state_d = StFin;
                  else if (mode_q)        state_d = StWr;
                  else                    state_d = StRd;
               end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = '0;
      mem_dbw  = '0;
      unique case (state_q)
         StRd: begin
            mem_rd   = 1'b1;
            mem_addr = src_q;
         end
         StWr: begin
            mem_wr   = 1'b1;
            mem_addr = dst_q;
            mem_dbw  = mode_q ? fill_q : data_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      fill_d   = fill_q;
      data_d   = data_q;
      mode_d   = mode_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      if (cpu_we && !busy) begin
         case (cpu_addr)
            REG_SRC_LO: src_d[7:0]       = cpu_dbw;
            REG_SRC_HI: src_d[LEN_W-1:8] = cpu_dbw;
            REG_DST_LO: dst_d[7:0]       = cpu_dbw;
            REG_DST_HI: dst_d[LEN_W-1:8] = cpu_dbw;
            REG_LEN_LO: len_d[7:0]       = cpu_dbw;
            REG_LEN_HI: len_d[LEN_W-1:8] = cpu_dbw;
            REG_FILL:   fill_d           = cpu_dbw;
            REG_CTRL:   mode_d           = cpu_dbw[CTL_MODE];
            default: ;
         endcase
      end
      if (ctrl_wr) irq_en_d = cpu_dbw[CTL_IRQ_EN];
      if (state_q == StCap) data_d = mem_dbr;
      if (xfer) begin
         dst_d = dst_q + LEN_W'(1);
         len_d = len_q - LEN_W'(1);
         if (!mode_q) src_d = src_q + LEN_W'(1);
      end
      if (start_req || (cpu_we && cpu_addr == REG_DONE_CLR)) done_d = 1'b0;
      // Completion beats a simultaneous done-clear.
      if (state_q == StFin && !abort_req) done_d = 1'b1;
   end

   always_comb begin
      dbr_d = cpu_dbr;
      if (!cpu_we) begin
         case (cpu_addr)
            REG_SRC_LO: dbr_d = src_q[7:0];
            REG_SRC_HI: dbr_d = src_q[LEN_W-1:8];
            REG_DST_LO: dbr_d = dst_q[7:0];
            REG_DST_HI: dbr_d = dst_q[LEN_W-1:8];
            REG_LEN_LO: dbr_d = len_q[7:0];
            REG_LEN_HI: dbr_d = len_q[LEN_W-1:8];
            REG_FILL:   dbr_d = fill_q;
            REG_CTRL:   dbr_d = {busy, done_q, 3'b000, irq_en_q, mode_q, 1'b0};
            default:    dbr_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         fill_q   <= '0;
         data_q   <= '0;
         mode_q   <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         cpu_dbr  <= '0;
      end else begin
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         mode_q   <= mode_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         cpu_dbr  <= dbr_d;
      end
   end

endmodule

// File: tb/tb_vram_blitter.sv
// Directed bench for vram_blitter: a byte-level memory model predicts every write,
// a negedge process checks the memory port each cycle and evaluates posted literal checks.
module tb_vram_blitter;
   import vram_blitter_pkg::*;

   logic        cpu_clk = 1'b0;
   logic        rst;
   logic [3:0]  cpu_addr;
   logic [7:0]  cpu_dbw;
   logic        cpu_we;
   logic [7:0]  cpu_dbr;
   logic        cpu_irq;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_dbw;
   logic [7:0]  mem_dbr = 8'hEE;
   logic        mem_ready;

   vram_blitter #(.LEN_W(16)) dut (
      .cpu_clk   (cpu_clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_dbw   (cpu_dbw),
      .cpu_we    (cpu_we),
      .cpu_dbr   (cpu_dbr),
      .cpu_irq   (cpu_irq),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_dbw   (mem_dbw),
      .mem_dbr   (mem_dbr),
      .mem_ready (mem_ready)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Owned by the main process: stimulus, model and posted literal checks.
   logic [7:0]  seed      [logic [15:0]];
   logic [7:0]  model_mem [logic [15:0]];
   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   int          flush_to = 0;
   string       lit_name[$];
   logic [31:0] lit_act[$];
   logic [31:0] lit_exp[$];
   logic [7:0]  s;
   int          w0, wa0, r0, n;

   // Owned by the compare process.
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_rd = 0;
   int          lit_rd = 0;
   int          wr_acc = 0;
   int          wr_seen = 0;
   int          wr_cyc[$];
   int          rd_cyc[$];
   logic [7:0]  vram [logic [15:0]];
   logic        pend = 1'b0;
   logic [7:0]  pend_data = 8'h00;
   logic        p_hold = 1'b0;
   logic [25:0] p_bus = '0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] mem_read(input logic [15:0] a);
      if (vram.exists(a)) return vram[a];
      if (seed.exists(a)) return seed[a];
      return 8'h00;
   endfunction

   function automatic logic [7:0] model_rd(input logic [15:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      if (seed.exists(a)) return seed[a];
      return 8'h00;
   endfunction

   always @(negedge cpu_clk) begin
      cyc++;
      while (lit_rd < lit_name.size()) begin
         check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
         lit_rd++;
      end
      if (exp_rd < flush_to) exp_rd = flush_to;
      // Read data appears in the cycle after the accepted read, garbage otherwise.
      mem_dbr = pend ? pend_data : 8'hEE;
      pend = 1'b0;
      if (rst) begin
         p_hold = 1'b0;
      end else begin
         if (p_hold) check("stall_hold", {mem_rd, mem_wr, mem_addr, mem_dbw}, p_bus);
         if (mem_rd || mem_wr) check("rd_wr_exclusive", {31'b0, mem_rd && mem_wr}, 32'd0);
         if (mem_rd) begin
            rd_cyc.push_back(cyc);
            if (mem_ready) begin
               pend = 1'b1;
               pend_data = mem_read(mem_addr);
            end
         end
         if (mem_wr) wr_seen++;
         if (mem_wr && mem_ready) begin
            wr_cyc.push_back(cyc);
            vram[mem_addr] = mem_dbw;
            wr_acc++;
            if (exp_rd < exp_addr.size()) begin
               check("wr_addr", {16'h0, mem_addr}, {16'h0, exp_addr[exp_rd]});
               check("wr_data", {24'h0, mem_dbw}, {24'h0, exp_data[exp_rd]});
               exp_rd++;
            end else begin
               check("unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end
         end
         p_hold = (mem_rd || mem_wr) && !mem_ready && !cpu_we;
         p_bus  = {mem_rd, mem_wr, mem_addr, mem_dbw};
      end
   end

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      lit_name.push_back(name);
      lit_act.push_back(act);
      lit_exp.push_back(exp);
   endtask

   task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_dbw  = d;
      cpu_we   = 1'b1;
      tick();
      cpu_we   = 1'b0;
   endtask

   task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
      cpu_addr = a;
      cpu_we   = 1'b0;
      tick();
      d = cpu_dbr;
   endtask

   task automatic setup(input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input logic [7:0] fill);
      cpu_wr(REG_SRC_LO, src[7:0]);
      cpu_wr(REG_SRC_HI, src[15:8]);
      cpu_wr(REG_DST_LO, dst[7:0]);
      cpu_wr(REG_DST_HI, dst[15:8]);
      cpu_wr(REG_LEN_LO, len[7:0]);
      cpu_wr(REG_LEN_HI, len[15:8]);
      cpu_wr(REG_FILL, fill);
   endtask

   task automatic wait_idle(input int budget);
      logic [7:0] st;
      int k;
      k = 0;
      do begin
         cpu_rd(REG_CTRL, st);
         k++;
      end while (st[7] && k < budget);
      expect_eq("busy_cleared", {31'b0, st[7]}, 32'd0);
   endtask

   task automatic model_fill(input logic [15:0] dst, input int len, input logic [7:0] v);
      for (int i = 0; i < len; i++) begin
         exp_addr.push_back(dst + 16'(i));
         exp_data.push_back(v);
         model_mem[dst + 16'(i)] = v;
      end
   endtask

   task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = model_rd(src + 16'(i));
         model_mem[dst + 16'(i)] = d;
         exp_addr.push_back(dst + 16'(i));
         exp_data.push_back(d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_dbw = 8'd0; mem_ready = 1'b1;
      #2 rst = 1'b1;
      #10;
      expect_eq("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
      expect_eq("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
      expect_eq("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
      expect_eq("rst_cpu_irq", {31'b0, cpu_irq}, 32'd0);
      expect_eq("rst_cpu_dbr", {24'h0, cpu_dbr}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Fill four bytes at 0x1000.
      setup(16'h0000, 16'h1000, 16'd4, 8'hA5);
      cpu_rd(REG_FILL, s);
      expect_eq("fill_reg_read", {24'h0, s}, 32'hA5);
      cpu_rd(4'd9, s);
      expect_eq("reg9_read", {24'h0, s}, 32'h00);
      model_fill(16'h1000, 4, 8'hA5);
      w0 = wr_cyc.size();
      cpu_wr(REG_CTRL, 8'h03);
      wait_idle(40);
      cpu_rd(REG_CTRL, s);
      expect_eq("fill_status", {24'h0, s}, 32'h42);
      expect_eq("fill_cadence", wr_cyc[w0 + 3] - wr_cyc[w0], 32'd3);
      expect_eq("fill_mem_1000", {24'h0, mem_read(16'h1000)}, 32'hA5);
      expect_eq("fill_mem_1003", {24'h0, mem_read(16'h1003)}, 32'hA5);

      // Copy three bytes 0x2000 -> 0x3000.
      seed[16'h2000] = 8'h11; seed[16'h2001] = 8'h22; seed[16'h2002] = 8'h33;
      setup(16'h2000, 16'h3000, 16'd3, 8'h00);
      model_copy(16'h2000, 16'h3000, 3);
      w0 = wr_cyc.size();
      r0 = rd_cyc.size();
      cpu_wr(REG_CTRL, 8'h01);
      wait_idle(40);
      expect_eq("copy_rd_to_last_wr", wr_cyc[w0 + 2] - rd_cyc[r0], 32'd8);
      expect_eq("copy_cadence", wr_cyc[w0 + 1] - wr_cyc[w0], 32'd3);
      expect_eq("copy_mem_3000", {24'h0, mem_read(16'h3000)}, 32'h11);
      expect_eq("copy_mem_3001", {24'h0, mem_read(16'h3001)}, 32'h22);
      expect_eq("copy_mem_3002", {24'h0, mem_read(16'h3002)}, 32'h33);
      cpu_rd(REG_SRC_LO, s);
      expect_eq("copy_src_lo", {24'h0, s}, 32'h03);
      cpu_rd(REG_CTRL, s);
      expect_eq("copy_status", {24'h0, s}, 32'h40);

      // Stalled single-byte copy.
      seed[16'h4000] = 8'h77;
      setup(16'h4000, 16'h5000, 16'd1, 8'h00);
      model_copy(16'h4000, 16'h5000, 1);
      r0 = rd_cyc.size();
      w0 = wr_seen;
      wa0 = wr_acc;
      mem_ready = 1'b0;
      cpu_wr(REG_CTRL, 8'h01);
      repeat (5) tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      repeat (3) tick();
      mem_ready = 1'b1;
      tick();
      wait_idle(20);
      expect_eq("stall_rd_cycles", rd_cyc.size() - r0, 32'd6);
      expect_eq("stall_wr_cycles", wr_seen - w0, 32'd4);
      expect_eq("stall_wr_accepted", wr_acc - wa0, 32'd1);
      expect_eq("stall_mem_5000", {24'h0, mem_read(16'h5000)}, 32'h77);

      // Fill across the top of the address space.
      setup(16'h0000, 16'hFFFE, 16'd3, 8'h3C);
      model_fill(16'hFFFE, 3, 8'h3C);
      cpu_wr(REG_CTRL, 8'h03);
      wait_idle(20);
      expect_eq("wrap_mem_ffff", {24'h0, mem_read(16'hFFFF)}, 32'h3C);
      expect_eq("wrap_mem_0000", {24'h0, mem_read(16'h0000)}, 32'h3C);
      cpu_rd(REG_DST_LO, s);
      expect_eq("wrap_dst_lo", {24'h0, s}, 32'h01);
      cpu_rd(REG_DST_HI, s);
      expect_eq("wrap_dst_hi", {24'h0, s}, 32'h00);

      // Zero length: one busy cycle, no memory traffic, start clears the old done.
      setup(16'h0000, 16'h2222, 16'd0, 8'h00);
      w0 = wr_seen;
      r0 = rd_cyc.size();
      cpu_wr(REG_CTRL, 8'h01);
      cpu_rd(REG_CTRL, s);
      expect_eq("len0_fin_status", {24'h0, s}, 32'h80);
      cpu_rd(REG_CTRL, s);
      expect_eq("len0_done_status", {24'h0, s}, 32'h40);
      expect_eq("len0_no_access", (wr_seen - w0) + (rd_cyc.size() - r0), 32'd0);

      // IRQ-enabled fill of 100, aborted after ten writes.
      setup(16'h0000, 16'hA000, 16'd100, 8'h5C);
      model_fill(16'hA000, 100, 8'h5C);
      wa0 = wr_acc;
      cpu_wr(REG_CTRL, 8'h07);
      n = 0;
      while (wr_acc - wa0 < 10 && n < 500) begin
         tick();
         n++;
      end
      mem_ready = 1'b0;
      expect_eq("abort_write_count", wr_acc - wa0, 32'd10);
      cpu_wr(REG_CTRL, 8'h0C);
      flush_to = exp_addr.size();
      mem_ready = 1'b1;
      tick();
      cpu_rd(REG_CTRL, s);
      expect_eq("abort_status", {24'h0, s}, 32'h06);
      expect_eq("abort_irq", {31'b0, cpu_irq}, 32'd0);
      cpu_rd(REG_LEN_LO, s);
      expect_eq("abort_len_lo", {24'h0, s}, 32'd90);
      cpu_rd(REG_DST_LO, s);
      expect_eq("abort_dst_lo", {24'h0, s}, 32'h0A);
      model_fill(16'hA00A, 90, 8'h5C);
      cpu_wr(REG_CTRL, 8'h07);
      wait_idle(300);
      expect_eq("restart_irq", {31'b0, cpu_irq}, 32'd1);
      cpu_wr(REG_DONE_CLR, 8'h00);
      expect_eq("done_clr_irq", {31'b0, cpu_irq}, 32'd0);

      // Register writes during a fill are ignored; read data holds across a write.
      setup(16'h0000, 16'h6000, 16'd8, 8'h99);
      model_fill(16'h6000, 8, 8'h99);
      cpu_wr(REG_CTRL, 8'h03);
      cpu_rd(REG_FILL, s);
      cpu_wr(REG_FILL, 8'h11);
      expect_eq("dbr_hold_on_write", {24'h0, cpu_dbr}, 32'h99);
      cpu_wr(REG_DST_LO, 8'h80);
      cpu_wr(REG_DST_HI, 8'h70);
      cpu_rd(REG_FILL, s);
      expect_eq("busy_fill_locked", {24'h0, s}, 32'h99);
      wait_idle(40);

      // Reset in the middle of a fill.
      setup(16'h0000, 16'h8000, 16'd50, 8'h42);
      model_fill(16'h8000, 50, 8'h42);
      wa0 = wr_acc;
      cpu_wr(REG_CTRL, 8'h03);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      expect_eq("midrst_mem_wr", {31'b0, mem_wr}, 32'd0);
      expect_eq("midrst_mem_addr", {16'h0, mem_addr}, 32'd0);
      expect_eq("midrst_mem_dbw", {24'h0, mem_dbw}, 32'd0);
      flush_to = exp_addr.size();
      tick();
      rst = 1'b0;
      tick();
      expect_eq("midrst_writes", wr_acc - wa0, 32'd3);
      for (int r = 0; r < 8; r++) begin
         cpu_rd(4'(r), s);
         expect_eq($sformatf("midrst_reg%0d", r), {24'h0, s}, 32'h00);
      end

      tick();
      expect_eq("all_writes_seen", exp_rd, exp_addr.size());
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_blitter.md
Name: vram_blitter

Overview:
CPU-programmed DMA engine that writes video RAM: block copy (memory to memory) or constant fill. It is the writer side of the video memory that the display generator reads. It sits on the CPU bus as a 16-register I/O page and owns a byte-wide memory port into the video RAM arbiter. It raises an IRQ on completion.

Parameters:
LEN_W, 16, width of length, source and destination counters (16-bit address space)

Ports:
cpu_clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_addr  in  4  register select
cpu_dbw  in  8  CPU write data
cpu_we  in  1  CPU register write enable
cpu_dbr  out  8  registered CPU read data
cpu_irq  out  1  level interrupt = done & irq_en
mem_addr  out  16  video RAM address
mem_rd  out  1  read request
mem_wr  out  1  write request
mem_dbw  out  8  write data
mem_dbr  in  8  read data, valid the cycle after an accepted read
mem_ready  in  1  arbiter grant; a request is accepted in a cycle where mem_ready=1

Behaviour:
- Reset: all registers 0; state IDLE; cpu_dbr=0; mem_rd=mem_wr=0; mem_addr=0; mem_dbw=0; cpu_irq=0.
- Registers:
  - 0/1: src lo/hi.
  - 2/3: dst lo/hi.
  - 4/5: len lo/hi.
  - 6: fill value.
  - 7 write: bit0 start, bit1 mode (0 copy, 1 fill), bit2 irq_en, bit3 abort.
  - 7 read: {busy, done, 3'b0, irq_en, mode, 1'b0}.
  - 8 write (any data): clear done.
  - 9–15: reads return 0, writes are ignored.
- cpu_dbr is updated every cycle with cpu_we=0 from cpu_addr. It holds its value while cpu_we=1.
- While busy, writes to registers 0–6 are ignored. A reg 7 write updates only irq_en and abort; start is ignored.
- Reads of 0–5 while busy return the live counters.
- Start with len=0: no memory access; done set one cycle later. Start also clears done.
- FSM states: IDLE, RD, CAP, WR, FIN.
  - IDLE: a start with len≠0 goes to RD (copy) or WR (fill).
  - RD: mem_rd=1, mem_addr=src. If mem_ready=1, go to CAP; else hold.
  - CAP: latch mem_dbr into data register, go to WR.
  - WR: mem_wr=1, mem_addr=dst, mem_dbw=data (copy) or fill value (fill). If mem_ready=1: dst+=1, src+=1 (copy only), len-=1. If old len==1, go to FIN; else go to RD (copy) or stay in WR (fill). If mem_ready=0, hold all outputs stable.
  - FIN: set done, go to IDLE.
- mem_rd/mem_wr/mem_addr/mem_dbw are decoded from state and counters (combinational). mem_rd and mem_wr are never both 1.
- Throughput with mem_ready=1: copy is 3 cycles/byte; fill is 1 cycle/byte.
- Counters wrap modulo 2^16 (dst 0xFFFF+1 → 0x0000). Overlapping copy runs in ascending order only; the result is defined byte-by-byte as sequential.
- busy = state≠IDLE.
- Abort (bit3) in any busy state: go to IDLE next cycle. The in-progress access is dropped; done is not set; counters keep their current values.
- Simultaneous done-clear (reg 8) and FIN in the same cycle: FIN wins, done=1.
- Reset mid-transfer: immediate IDLE with all outputs at reset values.

Decomposition:
- Shared package holds:
  - register offset constants (REG_SRC_LO … REG_DONE_CLR);
  - control bit positions;
  - FSM state encoding, 3 bits.
- No sub-module; a single module covers the CPU register file, counters and FSM.

Test Plan:
- Fill: dst=0x1000, len=4, fill=0xA5, mode=1, start, mem_ready=1 → four writes of 0xA5 to 0x1000–0x1003 on consecutive cycles; done=1 after FIN; reg 7 reads 0x42.
- Copy: src=0x2000 holds 11,22,33, dst=0x3000, len=3, start → read/capture/write per byte; 0x3000–0x3002 = 11,22,33; 9 cycles from RD entry to FIN.
- Stall: copy len=1 with mem_ready low for 5 cycles in RD and 3 cycles in WR → mem_rd/mem_wr and mem_addr held stable; exactly one write of the correct byte.
- Wrap + len=0: fill dst=0xFFFE, len=3 → writes to 0xFFFE, 0xFFFF, 0x0000. Separately, start with len=0 → no mem_wr; done after 1 cycle.
- IRQ/abort: irq_en=1, fill len=100, abort after 10 writes → busy=0, done=0, cpu_irq=0, len reads 90. Then restart → cpu_irq=1 at completion; reg 8 write → cpu_irq=0.
- Busy lockout + reset: writing dst during a fill does not change the write sequence. Asserting rst mid-fill → mem_wr=0 immediately; all registers 0.
